// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and sizing helpers for the audio frame path
package audio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_WAIT_SYNC,
        ST_OUTPUT,
        ST_DRAIN
    } afe_state_t;

    // Complex samples travel as {real, imag}, each half one real sample wide.
    function automatic int afe_cplx_w(input int sample_w);
        return 2 * sample_w;
    endfunction

    function automatic int afe_spw(input int word_w, input int sample_w);
        return word_w / sample_w;
    endfunction

    function automatic int afe_words_per_frame(input int samples, input int word_w,
                                               input int sample_w);
        return samples / (word_w / sample_w);
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int afe_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/afe_frame_buffer.sv
// rtl/afe_frame_buffer.sv - per-channel frame store, word-wide write, sample-wide read
module afe_frame_buffer
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int WORD_W   = 512,
    parameter int SAMPLES  = 2048,
    parameter int CHANNELS = 2,
    localparam int CW  = afe_idx_w(CHANNELS),
    localparam int IW  = afe_idx_w(afe_words_per_frame(SAMPLES, WORD_W, SAMPLE_W)),
    localparam int NW  = afe_idx_w(SAMPLES),
    localparam int SPW = afe_spw(WORD_W, SAMPLE_W)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                busy_i,
    input  logic                wr_en_i,
    input  logic [CW-1:0]       wr_chan_i,
    input  logic [IW-1:0]       wr_index_i,
    input  logic [WORD_W-1:0]   wr_data_i,
    output logic                wr_err_o,
    input  logic [CW-1:0]       rd_chan_i,
    input  logic [NW-1:0]       rd_index_i,
    output logic [SAMPLE_W-1:0] rd_sample_o
);

    logic [SAMPLE_W-1:0] mem_q [CHANNELS][SAMPLES];
    logic                chan_ok;
    logic                wr_ok;
    logic                wr_err_q;

    assign chan_ok = int'(wr_chan_i) < CHANNELS;
    assign wr_ok   = wr_en_i && !busy_i && chan_ok;

    // Storage is deliberately left out of reset so a mid-run reset keeps the frame.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            for (int k = 0; k < SPW; k++) begin
                mem_q[wr_chan_i][NW'(int'(wr_index_i) * SPW + k)] <= wr_data_i[k*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_en_i && !wr_ok;
        end
    end

    assign wr_err_o    = wr_err_q;
    assign rd_sample_o = mem_q[rd_chan_i][rd_index_i];

endmodule

// File: rtl/audio_frame_engine.sv
// rtl/audio_frame_engine.sv - multi-channel frame sequencer around an external transform core
module audio_frame_engine
    import audio_pkg::*;
#(
    parameter int SAMPLE_W     = 16,
    parameter int WORD_W       = 512,
    parameter int SAMPLES      = 2048,
    parameter int CHANNELS     = 2,
    parameter int DRAIN_CYCLES = 8,
    parameter int SYNC_TIMEOUT = 8192,
    localparam int CW = afe_idx_w(CHANNELS),
    localparam int IW = afe_idx_w(afe_words_per_frame(SAMPLES, WORD_W, SAMPLE_W)),
    localparam int NW = afe_idx_w(SAMPLES),
    localparam int XW = afe_cplx_w(SAMPLE_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bypass,
    input  logic              wr_en,
    input  logic [CW-1:0]     wr_chan,
    input  logic [IW-1:0]     wr_index,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_err,
    output logic              xf_ce,
    output logic [XW-1:0]     xf_sample,
    input  logic              xf_sync,
    input  logic [XW-1:0]     xf_result,
    output logic              out_valid,
    output logic [XW-1:0]     out_data,
    output logic [NW-1:0]     out_index,
    output logic [CW-1:0]     out_chan,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int TW = $clog2(SYNC_TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    localparam logic [NW-1:0] LAST_CNT   = NW'(SAMPLES - 1);
    localparam logic [TW-1:0] LAST_TCNT  = TW'(SYNC_TIMEOUT - 1);
    localparam logic [DW-1:0] LAST_DCNT  = DW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] LAST_CHAN  = CW'(CHANNELS - 1);

    afe_state_t          state_q, state_d;
    logic [CW-1:0]       chan_q, chan_d;
    logic [NW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [DW-1:0]       dcnt_q, dcnt_d;
    logic                bypass_q, bypass_d;
    logic                terr_q, terr_d;
    logic [SAMPLE_W-1:0] rd_sample;

    afe_frame_buffer #(
        .SAMPLE_W (SAMPLE_W),
        .WORD_W   (WORD_W),
        .SAMPLES  (SAMPLES),
        .CHANNELS (CHANNELS)
    ) u_buf (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .busy_i      (busy),
        .wr_en_i     (wr_en),
        .wr_chan_i   (wr_chan),
        .wr_index_i  (wr_index),
        .wr_data_i   (wr_data),
        .wr_err_o    (wr_err),
        .rd_chan_i   (chan_q),
        .rd_index_i  (cnt_q),
        .rd_sample_o (rd_sample)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            chan_q   <= '0;
            cnt_q    <= '0;
            tcnt_q   <= '0;
            dcnt_q   <= '0;
            bypass_q <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            dcnt_q   <= dcnt_d;
            bypass_q <= bypass_d;
            terr_q   <= terr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        dcnt_d    = dcnt_q;
        bypass_d  = bypass_q;
        terr_d    = terr_q;
        xf_ce     = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    chan_d   = '0;
                    cnt_d    = '0;
                    tcnt_d   = '0;
                    dcnt_d   = '0;
                    bypass_d = bypass;
                    terr_d   = 1'b0;
                    state_d  = bypass ? ST_OUTPUT : ST_FEED;
                end
            end

            ST_FEED: begin
                xf_ce = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    tcnt_d  = '0;
                    state_d = ST_WAIT_SYNC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // The sync cycle itself carries bin 0, so OUTPUT resumes at bin 1.
            ST_WAIT_SYNC: begin
                xf_ce = 1'b1;
                if (xf_sync) begin
                    out_valid = 1'b1;
                    out_data  = xf_result;
                    cnt_d     = NW'(1);
                    tcnt_d    = '0;
                    state_d   = ST_OUTPUT;
                end else if (tcnt_q == LAST_TCNT) begin
                    terr_d  = 1'b1;
                    tcnt_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            ST_OUTPUT: begin
                out_valid = 1'b1;
                if (bypass_q) begin
                    out_data = {rd_sample, {SAMPLE_W{1'b0}}};
                end else begin
                    xf_ce    = 1'b1;
                    out_data = xf_result;
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    dcnt_d  = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DRAIN: begin
                if (dcnt_q == LAST_DCNT) begin
                    dcnt_d = '0;
                    if (chan_q < LAST_CHAN) begin
                        chan_d  = chan_q + 1'b1;
                        state_d = bypass_q ? ST_OUTPUT : ST_FEED;
                    end else begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign xf_sample   = {rd_sample, {SAMPLE_W{1'b0}}};
    assign out_index   = cnt_q;
    assign out_chan    = chan_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = terr_q;

endmodule
